// File: rtl/lif_accum_fire.sv
// Leaky integrate-and-fire array: accumulates a signed weight stream into membrane
// potentials, then leaks/thresholds on timestep end and streams spike events.
// Optional LIF_SUBTRACT_RESET_EN: a firing neuron keeps v - threshold instead of 0.
module lif_accum_fire #(
  parameter int NUM_NEURONS       = 256,
  parameter int BEATS_PER_BURST   = 64,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int VMEM_WIDTH        = 16,
  parameter int S_AXIS_DATA_WIDTH = 32,
  parameter int M_AXIS_DATA_WIDTH = 32
) (
  input  logic                         axi_aclk,
  input  logic                         axi_areset,
  input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [7:0]                   s_axis_tid,
  output logic [M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  input  logic                         ctrl_timestep_end,
  input  logic [VMEM_WIDTH-1:0]        ctrl_threshold,
  input  logic [VMEM_WIDTH-1:0]        ctrl_leak,
  output logic                         status_misalign,
  output logic                         status_partial,
  output logic                         status_busy
);

  localparam int LANES  = S_AXIS_DATA_WIDTH / WEIGHT_WIDTH;
  localparam int LANE_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(BEATS_PER_BURST);
  localparam int IDX_W  = $clog2(NUM_NEURONS);
  localparam int TS_W   = 16;
  localparam logic [VMEM_WIDTH-1:0] VMAX = {1'b0, {(VMEM_WIDTH-1){1'b1}}};
  localparam logic [VMEM_WIDTH-1:0] VMIN = {1'b1, {(VMEM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {ACCUM, SCAN, EMIT, MARK} state_e;

  state_e                                  state_q;
  logic [NUM_NEURONS-1:0][VMEM_WIDTH-1:0]  vmem_q;
  logic [CNT_W-1:0]                        cnt_q;
  logic [7:0]                              last_tid_q;
  logic [IDX_W-1:0]                        idx_q;
  logic [TS_W-1:0]                         ts_q;
  logic                                    pending_q;
  logic                                    tready_q;
  logic                                    tvalid_q;
  logic                                    tlast_q;
  logic [M_AXIS_DATA_WIDTH-1:0]            tdata_q;
  logic                                    misalign_q;
  logic                                    partial_q;

  logic                                    accept;
  logic                                    tid_jump;
  logic [CNT_W-1:0]                        beat_idx;
  logic [CNT_W-1:0]                        cnt_d;
  logic [IDX_W-1:0]                        base;
  logic [LANES-1:0][VMEM_WIDTH-1:0]        lane_sum;
  logic [VMEM_WIDTH-1:0]                   v_cur;
  logic signed [VMEM_WIDTH+1:0]            v_ext;
  logic signed [VMEM_WIDTH+1:0]            l_ext;
  logic signed [VMEM_WIDTH+1:0]            leak_res;
  logic [VMEM_WIDTH-1:0]                   leaked;
  logic [VMEM_WIDTH-1:0]                   fire_val;
  logic                                    fire;
  logic                                    last_idx;
  logic                                    close_ts;

  function automatic logic [VMEM_WIDTH-1:0] sat_add(input logic [VMEM_WIDTH-1:0] v,
                                                    input logic [WEIGHT_WIDTH-1:0] w);
    logic [VMEM_WIDTH:0] s;
    s = {v[VMEM_WIDTH-1], v} + {{(VMEM_WIDTH+1-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
    if (s[VMEM_WIDTH] != s[VMEM_WIDTH-1]) sat_add = s[VMEM_WIDTH] ? VMIN : VMAX;
    else sat_add = s[VMEM_WIDTH-1:0];
  endfunction

  // A tid change mid-burst means the read stage restarted; realign to beat 0.
  assign accept   = s_axis_tvalid & tready_q;
  assign tid_jump = accept && (s_axis_tid != last_tid_q) && (cnt_q != '0);
  assign beat_idx = tid_jump ? '0 : cnt_q;
  assign cnt_d    = accept ? beat_idx + CNT_W'(1) : cnt_q;
  assign base     = IDX_W'({beat_idx, {LANE_W{1'b0}}});
  assign last_idx = (idx_q == IDX_W'(NUM_NEURONS - 1));
  assign close_ts = pending_q | ctrl_timestep_end;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum[i] = sat_add(vmem_q[base + IDX_W'(i)],
                            s_axis_tdata[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end
  end

  // Leak pulls toward zero; two guard bits keep v +/- leak from overflowing.
  always_comb begin
    v_cur = vmem_q[idx_q];
    v_ext = $signed({{2{v_cur[VMEM_WIDTH-1]}}, v_cur});
    l_ext = $signed({2'b00, ctrl_leak});
    if (v_ext > l_ext)       leak_res = v_ext - l_ext;
    else if (v_ext < -l_ext) leak_res = v_ext + l_ext;
    else                     leak_res = '0;
    leaked = leak_res[VMEM_WIDTH-1:0];
    fire   = $signed(leaked) >= $signed(ctrl_threshold);
`ifdef LIF_SUBTRACT_RESET_EN
    fire_val = leaked - ctrl_threshold;
`else
    fire_val = '0;
`endif
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q    <= ACCUM;
      vmem_q     <= '0;
      cnt_q      <= '0;
      last_tid_q <= '0;
      idx_q      <= '0;
      ts_q       <= '0;
      pending_q  <= 1'b0;
      tready_q   <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tdata_q    <= '0;
      misalign_q <= 1'b0;
      partial_q  <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            last_tid_q <= s_axis_tid;
            cnt_q      <= cnt_d;
            if (tid_jump) misalign_q <= 1'b1;
            for (int i = 0; i < LANES; i++) vmem_q[base + IDX_W'(i)] <= lane_sum[i];
          end
          if (close_ts) begin
            state_q   <= SCAN;
            idx_q     <= '0;
            pending_q <= 1'b0;
            tready_q  <= 1'b0;
            if (cnt_d != '0) partial_q <= 1'b1;
          end else begin
            tready_q <= 1'b1;
          end
        end
        SCAN: begin
          if (ctrl_timestep_end) pending_q <= 1'b1;
          vmem_q[idx_q] <= fire ? fire_val : leaked;
          if (fire) begin
            state_q  <= EMIT;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= M_AXIS_DATA_WIDTH'({ts_q, TS_W'(idx_q)});
          end else if (last_idx) begin
            state_q  <= MARK;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b1;
            tdata_q  <= M_AXIS_DATA_WIDTH'({ts_q, {TS_W{1'b1}}});
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        EMIT: begin
          if (ctrl_timestep_end) pending_q <= 1'b1;
          if (m_axis_tready) begin
            if (last_idx) begin
              state_q <= MARK;
              tlast_q <= 1'b1;
              tdata_q <= M_AXIS_DATA_WIDTH'({ts_q, {TS_W{1'b1}}});
            end else begin
              state_q  <= SCAN;
              idx_q    <= idx_q + IDX_W'(1);
              tvalid_q <= 1'b0;
            end
          end
        end
        MARK: begin
          pending_q <= close_ts;
          if (m_axis_tready) begin
            state_q  <= ACCUM;
            ts_q     <= ts_q + TS_W'(1);
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tready_q <= ~close_ts;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign s_axis_tready   = tready_q;
  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign status_misalign = misalign_q;
  assign status_partial  = partial_q;
  assign status_busy     = (state_q != ACCUM);

endmodule
